// File: rtl/note_sequencer_ctrl_if.sv
// Purpose: note RAM bus between the sequencer (master) and a 64x12 synchronous RAM (slave).
// Latency: read data is expected one cycle after ram_addr is presented; writes commit on the strobe edge.
// Backpressure: none; the RAM must accept a write or an address every cycle.
interface note_sequencer_ctrl_if;
    logic [5:0]  ram_addr;
    logic        ram_wr_en;
    logic [11:0] ram_wr_data;
    logic [11:0] ram_rd_data;

    modport master (
        output ram_addr,
        output ram_wr_en,
        output ram_wr_data,
        input  ram_rd_data
    );

    modport slave (
        input  ram_addr,
        input  ram_wr_en,
        input  ram_wr_data,
        output ram_rd_data
    );
endinterface

// File: rtl/note_sequencer_ctrl.sv
// Purpose: records key presses as {note,duration} entries into a 64-entry RAM and plays them back.
// Latency: a RAM write strobes one cycle after the event; the first note sounds 2 cycles after left_button.
// Backpressure: none; buttons and frame ticks are single-cycle pulses that are consumed or ignored.
module note_sequencer_ctrl (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    switches,
    input  logic                          center_button,
    input  logic                          left_button,
    input  logic                          new_frame,
    note_sequencer_ctrl_if.master         ram,
    output logic [3:0]                    note_out,
    output logic                          note_valid,
    output logic [1:0]                    mode,
    output logic [6:0]                    song_len,
    output logic                          full
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECORD,
        S_FETCH,
        S_LOAD,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  wr_ptr_q, wr_ptr_d;
    logic [6:0]  rd_ptr_q, rd_ptr_d;
    logic [3:0]  held_q, held_d;
    logic [7:0]  dur_q, dur_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [6:0]  song_len_q, song_len_d;
    logic        full_q, full_d;
    logic [3:0]  note_out_q, note_out_d;
    logic        note_valid_q, note_valid_d;
    logic [5:0]  ram_addr_q, ram_addr_d;
    logic        ram_wr_en_q, ram_wr_en_d;
    logic [11:0] ram_wr_data_q, ram_wr_data_d;

    logic [3:0]  enc;
    logic        do_write;
    logic [11:0] wr_entry;
    logic [6:0]  rd_ptr_inc;

    // Priority-encode the keys: the highest set bit wins, no key is a rest (0).
    always_comb begin
        enc = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (switches[i]) begin
                enc = 4'(i + 1);
            end
        end
    end

    assign rd_ptr_inc = rd_ptr_q + 7'd1;

    // State register and all datapath registers; reset drops any pending write or flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= 6'd0;
            rd_ptr_q      <= 7'd0;
            held_q        <= 4'd0;
            dur_q         <= 8'd0;
            cnt_q         <= 8'd0;
            song_len_q    <= 7'd0;
            full_q        <= 1'b0;
            note_out_q    <= 4'd0;
            note_valid_q  <= 1'b0;
            ram_addr_q    <= 6'd0;
            ram_wr_en_q   <= 1'b0;
            ram_wr_data_q <= 12'd0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            held_q        <= held_d;
            dur_q         <= dur_d;
            cnt_q         <= cnt_d;
            song_len_q    <= song_len_d;
            full_q        <= full_d;
            note_out_q    <= note_out_d;
            note_valid_q  <= note_valid_d;
            ram_addr_q    <= ram_addr_d;
            ram_wr_en_q   <= ram_wr_en_d;
            ram_wr_data_q <= ram_wr_data_d;
        end
    end

    // Next-state and datapath updates; center_button always outranks left_button.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        held_d        = held_q;
        dur_d         = dur_q;
        cnt_d         = cnt_q;
        song_len_d    = song_len_q;
        full_d        = full_q;
        note_out_d    = note_out_q;
        note_valid_d  = note_valid_q;
        ram_addr_d    = ram_addr_q;
        ram_wr_en_d   = 1'b0;
        ram_wr_data_d = ram_wr_data_q;
        do_write      = 1'b0;
        wr_entry      = {held_q, dur_q};

        case (state_q)
            S_IDLE: begin
                if (center_button) begin
                    state_d    = S_RECORD;
                    wr_ptr_d   = 6'd0;
                    song_len_d = 7'd0;
                    full_d     = 1'b0;
                    held_d     = enc;
                    dur_d      = 8'd0;
                end else if (left_button && (song_len_q != 7'd0)) begin
                    state_d    = S_FETCH;
                    rd_ptr_d   = 7'd0;
                    ram_addr_d = 6'd0;
                end
            end

            S_RECORD: begin
                if (center_button) begin
                    // Flush whatever is held; a zero-length entry is simply dropped.
                    do_write = (dur_q != 8'd0);
                    state_d  = S_IDLE;
                end else if (enc != held_q) begin
                    do_write = (dur_q != 8'd0);
                    held_d   = enc;
                    dur_d    = 8'd0;
                end else if (new_frame) begin
                    if (dur_q == 8'hFF) begin
                        // Saturated: emit a full entry and carry this frame into the next one.
                        do_write = 1'b1;
                        dur_d    = 8'd1;
                    end else begin
                        dur_d = dur_q + 8'd1;
                    end
                end

                if (do_write) begin
                    ram_wr_en_d   = 1'b1;
                    ram_addr_d    = wr_ptr_q;
                    ram_wr_data_d = wr_entry;
                    wr_ptr_d      = wr_ptr_q + 6'd1;
                    song_len_d    = song_len_q + 7'd1;
                    // The 64th entry fills the RAM: stop recording right here.
                    if (song_len_q == 7'd63) begin
                        full_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            S_FETCH: begin
                if (center_button) begin
                    state_d      = S_IDLE;
                    note_out_d   = 4'd0;
                    note_valid_d = 1'b0;
                end else begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                if (center_button) begin
                    state_d      = S_IDLE;
                    note_out_d   = 4'd0;
                    note_valid_d = 1'b0;
                end else begin
                    note_out_d   = ram.ram_rd_data[11:8];
                    cnt_d        = ram.ram_rd_data[7:0];
                    note_valid_d = 1'b1;
                    state_d      = S_HOLD;
                end
            end

            S_HOLD: begin
                if (center_button) begin
                    state_d      = S_IDLE;
                    note_out_d   = 4'd0;
                    note_valid_d = 1'b0;
                end else if (new_frame) begin
                    if (cnt_q <= 8'd1) begin
                        cnt_d    = 8'd0;
                        rd_ptr_d = rd_ptr_inc;
                        if (rd_ptr_inc < song_len_q) begin
                            state_d    = S_FETCH;
                            ram_addr_d = rd_ptr_inc[5:0];
                        end else begin
                            state_d      = S_IDLE;
                            note_out_d   = 4'd0;
                            note_valid_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Mode is a pure decode of the state; all playback sub-states report PLAY.
    always_comb begin
        case (state_q)
            S_IDLE:   mode = 2'd0;
            S_RECORD: mode = 2'd1;
            default:  mode = 2'd2;
        endcase
    end

    assign ram.ram_addr    = ram_addr_q;
    assign ram.ram_wr_en   = ram_wr_en_q;
    assign ram.ram_wr_data = ram_wr_data_q;
    assign note_out        = note_out_q;
    assign note_valid      = note_valid_q;
    assign song_len        = song_len_q;
    assign full            = full_q;

endmodule

// File: tb/tb_note_sequencer_ctrl.sv
module tb_note_sequencer_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  switches = 8'h00;
    logic        center_button = 1'b0;
    logic        left_button = 1'b0;
    logic        new_frame = 1'b0;
    logic [3:0]  note_out;
    logic        note_valid;
    logic [1:0]  mode;
    logic [6:0]  song_len;
    logic        full;

    int n_cmp = 0;
    int n_err = 0;
    int base;

    note_sequencer_ctrl_if bus ();

    note_sequencer_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .switches      (switches),
        .center_button (center_button),
        .left_button   (left_button),
        .new_frame     (new_frame),
        .ram           (bus),
        .note_out      (note_out),
        .note_valid    (note_valid),
        .mode          (mode),
        .song_len      (song_len),
        .full          (full)
    );

    always #5 clk = ~clk;

    // RAM model with synchronous read, plus a log of every write strobe seen.
    logic [11:0] mem [0:63];
    logic [5:0]  log_addr [0:127];
    logic [11:0] log_data [0:127];
    int          wr_count = 0;

    always @(posedge clk) begin
        if (bus.ram_wr_en) begin
            mem[bus.ram_addr] <= bus.ram_wr_data;
            if (wr_count < 128) begin
                log_addr[wr_count] <= bus.ram_addr;
                log_data[wr_count] <= bus.ram_wr_data;
            end
            wr_count <= wr_count + 1;
        end
        bus.ram_rd_data <= mem[bus.ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic frame_pulse();
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
        tick();
    endtask

    task automatic press_center();
        center_button = 1'b1;
        tick();
        center_button = 1'b0;
    endtask

    task automatic press_left();
        left_button = 1'b1;
        tick();
        left_button = 1'b0;
    endtask

    initial begin
        // Reset state while reset is held low
        #1;
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_note_valid", 32'(note_valid), 32'd0);
        check("rst_song_len", 32'(song_len), 32'd0);
        check("rst_wr_en", 32'(bus.ram_wr_en), 32'd0);
        #20;
        reset = 1'b1;
        tick();

        // Record 0x80 for 3 frames, rest for 2 frames, then stop
        switches = 8'h80;
        press_center();
        check("rec_mode", 32'(mode), 32'd1);
        check("rec_song_len0", 32'(song_len), 32'd0);
        frame_pulse(); frame_pulse(); frame_pulse();
        check("rec_no_early_write", 32'(wr_count), 32'd0);
        switches = 8'h00;
        tick();
        tick();
        check("rec_wr0_count", 32'(wr_count), 32'd1);
        check("rec_wr0_addr", 32'(log_addr[0]), 32'd0);
        check("rec_wr0_data", 32'(log_data[0]), 32'h803);
        check("rec_song_len1", 32'(song_len), 32'd1);
        frame_pulse(); frame_pulse();
        press_center();
        check("rec_stop_mode", 32'(mode), 32'd0);
        tick();
        check("rec_wr1_count", 32'(wr_count), 32'd2);
        check("rec_wr1_addr", 32'(log_addr[1]), 32'd1);
        check("rec_wr1_data", 32'(log_data[1]), 32'h002);
        check("rec_song_len2", 32'(song_len), 32'd2);

        // Playback of that recording
        press_left();
        check("play_mode", 32'(mode), 32'd2);
        tick();
        check("play_not_yet_valid", 32'(note_valid), 32'd0);
        tick();
        check("play_first_valid", 32'(note_valid), 32'd1);
        check("play_note8", 32'(note_out), 32'd8);
        frame_pulse();
        check("play_note8_f1", 32'(note_out), 32'd8);
        frame_pulse();
        check("play_note8_f2", 32'(note_out), 32'd8);
        frame_pulse();
        tick();
        check("play_rest", 32'(note_out), 32'd0);
        check("play_rest_valid", 32'(note_valid), 32'd1);
        check("play_rest_mode", 32'(mode), 32'd2);
        frame_pulse();
        check("play_rest_f1_mode", 32'(mode), 32'd2);
        frame_pulse();
        check("play_end_mode", 32'(mode), 32'd0);
        check("play_end_valid", 32'(note_valid), 32'd0);

        // Center stops playback mid-note
        press_left();
        tick();
        tick();
        check("stop_pre_valid", 32'(note_valid), 32'd1);
        press_center();
        check("stop_mode", 32'(mode), 32'd0);
        check("stop_note", 32'(note_out), 32'd0);
        check("stop_valid", 32'(note_valid), 32'd0);

        // One note held for 300 frames splits into 255 + 45
        base = wr_count;
        switches = 8'h08;
        press_center();
        for (int i = 0; i < 300; i++) frame_pulse();
        check("long_one_write", 32'(wr_count - base), 32'd1);
        check("long_wr0", 32'(log_data[base]), 32'h4FF);
        press_center();
        tick();
        check("long_two_writes", 32'(wr_count - base), 32'd2);
        check("long_wr1_addr", 32'(log_addr[base + 1]), 32'd1);
        check("long_wr1", 32'(log_data[base + 1]), 32'h42D);
        check("long_song_len", 32'(song_len), 32'd2);

        // 64 alternating notes fill the song
        base = wr_count;
        switches = 8'h01;
        press_center();
        for (int i = 0; i < 64; i++) begin
            frame_pulse();
            switches = (i % 2 == 0) ? 8'h02 : 8'h01;
            tick();
        end
        tick();
        check("fill_count", 32'(wr_count - base), 32'd64);
        check("fill_full", 32'(full), 32'd1);
        check("fill_mode", 32'(mode), 32'd0);
        check("fill_song_len", 32'(song_len), 32'd64);
        check("fill_last_addr", 32'(log_addr[base + 63]), 32'd63);
        check("fill_last_data", 32'(log_data[base + 63]), 32'h201);
        for (int i = 0; i < 4; i++) begin
            switches = (i % 2 == 0) ? 8'h40 : 8'h01;
            tick();
            frame_pulse();
        end
        check("fill_no_65th", 32'(wr_count - base), 32'd64);
        check("fill_still_idle", 32'(mode), 32'd0);

        // Reset in the middle of a held playback note
        press_left();
        tick();
        tick();
        check("hold_valid", 32'(note_valid), 32'd1);
        check("hold_note1", 32'(note_out), 32'd1);
        base = wr_count;
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_mode", 32'(mode), 32'd0);
        check("mid_rst_note", 32'(note_out), 32'd0);
        check("mid_rst_valid", 32'(note_valid), 32'd0);
        check("mid_rst_addr", 32'(bus.ram_addr), 32'd0);
        check("mid_rst_wr_en", 32'(bus.ram_wr_en), 32'd0);
        check("mid_rst_wr_data", 32'(bus.ram_wr_data), 32'd0);
        check("mid_rst_song_len", 32'(song_len), 32'd0);
        check("mid_rst_full", 32'(full), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_mode", 32'(mode), 32'd0);
        check("post_rst_song_len", 32'(song_len), 32'd0);
        check("post_rst_no_write", 32'(wr_count - base), 32'd0);

        // Center and left together from IDLE; center wins
        switches = 8'h05;
        center_button = 1'b1;
        left_button = 1'b1;
        tick();
        center_button = 1'b0;
        left_button = 1'b0;
        check("both_mode", 32'(mode), 32'd1);
        base = wr_count;
        press_center();
        tick();
        check("drop_zero_dur", 32'(wr_count - base), 32'd0);
        check("drop_song_len", 32'(song_len), 32'd0);
        press_left();
        check("left_empty_mode", 32'(mode), 32'd0);
        tick();
        check("left_empty_mode2", 32'(mode), 32'd0);

        // Priority encoding: 0x05 encodes as note 3
        press_center();
        frame_pulse();
        press_center();
        tick();
        check("prio_count", 32'(wr_count - base), 32'd1);
        check("prio_data", 32'(log_data[base]), 32'h301);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/note_sequencer_ctrl.md
NOTE_SEQUENCER_CTRL -- requirements
Module: note_sequencer_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port switches  in  8  note keys; one-hot in normal use.
REQ-004 SHALL have port center_button  in  1  single-cycle pulse; start/stop record, or stop playback.
REQ-005 SHALL have port left_button  in  1  single-cycle pulse; start playback.
REQ-006 SHALL have port new_frame  in  1  single-cycle tick; unit of note duration.
REQ-007 SHALL have port ram_addr  out  6  note RAM address.
REQ-008 SHALL have port ram_wr_en  out  1  note RAM write strobe.
REQ-009 SHALL have port ram_wr_data  out  12  RAM entry {note[11:8], dur[7:0]}.
REQ-010 SHALL have port ram_rd_data  in  12  RAM read data; valid one cycle after ram_addr is presented.
REQ-011 SHALL have port note_out  out  4  current playback note; 0 = rest.
REQ-012 SHALL have port note_valid  out  1  high while a playback entry is sounding.
REQ-013 SHALL have port mode  out  2  0 IDLE, 1 RECORD, 2 PLAY.
REQ-014 SHALL have port song_len  out  7  number of stored entries, 0..64.
REQ-015 SHALL have port full  out  1  sticky; set when recording stopped at 64 entries.

Function
REQ-016 SHALL encode switches by priority: bit7 -> 8, bit6 -> 7, ..., bit0 -> 1, none -> 0 (rest).
REQ-017 SHALL implement states IDLE, RECORD, FETCH, LOAD, HOLD; mode=2 in FETCH, LOAD and HOLD.
REQ-018 SHALL give center_button priority over left_button when both pulse in the same cycle.
REQ-019 SHALL, from IDLE on center_button, enter RECORD with wr_ptr=0, song_len=0, full=0, held note = current encoding, dur=0.
REQ-020 SHALL, in RECORD on a new_frame with an unchanged encoding, increment dur.
REQ-021 SHALL, in RECORD when the encoding differs from the held note: write {held,dur} at wr_ptr if dur>0 (wr_ptr++, song_len++), then set held=new and dur=0.
REQ-022 SHALL drop any entry whose dur is 0; no write occurs.
REQ-023 SHALL, on a new_frame with dur=255 and an unchanged note, write {held,255}, then set dur=1.
REQ-024 SHALL, on center_button in RECORD, flush the held entry when dur>0 and return to IDLE in the same cycle.
REQ-025 SHALL, after the write that makes song_len=64, set full=1, return to IDLE, and ignore the remaining frames.
REQ-026 SHALL assert ram_wr_en for exactly one cycle per write, with ram_addr=wr_ptr.
REQ-027 SHALL, on left_button in IDLE with song_len>0, enter FETCH with rd_ptr=0; with song_len=0 the pulse is ignored.
REQ-028 SHALL, in FETCH, drive ram_addr=rd_ptr and move to LOAD next cycle.
REQ-029 SHALL, in LOAD, capture ram_rd_data into note_out and the down-counter, set note_valid=1, and enter HOLD.
REQ-030 SHALL, in HOLD on new_frame, decrement the counter.
REQ-031 SHALL, when the counter reaches 0: increment rd_ptr; enter FETCH if rd_ptr<song_len, otherwise enter IDLE.
REQ-032 SHALL, on center_button in FETCH, LOAD or HOLD, enter IDLE next cycle with note_out=0 and note_valid=0.
REQ-033 SHALL ignore left_button outside IDLE and ignore switches outside RECORD.
REQ-034 SHALL produce a first note_valid 2 cycles after the left_button pulse.

Reset
REQ-035 SHALL, while reset=0, force IDLE, ram_addr=0, ram_wr_en=0, ram_wr_data=0, note_out=0, note_valid=0, mode=0, song_len=0, full=0, and clear all pointers and counters.
REQ-036 SHALL abort recording or playback on reset mid-operation, with no RAM write and no pending flush.

Verification
REQ-037 SHALL cover reset mid-HOLD: all outputs reach their REQ-035 values immediately, song_len=0, and mode=0 after release.
REQ-038 SHALL cover a record of switches 0x80 for 3 frames, then 0x00 for 2 frames, then center: writes 0x803 at addr 0 and 0x002 at addr 1; song_len=2.
REQ-039 SHALL cover playback of that recording: note_out=8 for 3 frames, then 0 for 2 frames, then mode=0 and note_valid=0.
REQ-040 SHALL cover one note held for 300 frames: entries 0x4FF and 0x42D (dur 45); song_len=2.
REQ-041 SHALL cover 64 alternating notes: full=1, mode=0 after the 64th write, and no write to a 65th address.
REQ-042 SHALL cover center and left pulsing in the same cycle from IDLE: mode=1; also left with song_len=0: mode stays 0.
